step_event_gen: RTL and testbench
=================================

Name: step_event_gen

Overview:
- Consumer stage placed directly after the 5-bit free-running step counter.
- Samples the counter value t every cycle, detects wrap (31->0) and discontinuities, and counts epochs (completed wraps).
- Emits match events when t equals a programmed step. Events are queued in a small FIFO and delivered over a valid/ready handshake to downstream control logic.
- Configured through a one-shot valid/ready config port; supports one-shot and periodic modes.

Parameters:
TW, 5, width of the step-counter input t (counter period 2**TW).
EPOCH_W, 3, width of the epoch counter (wraps counted while RUN).
DEPTH, 2, event FIFO depth (power of two, >=2).

Ports:
clk  in  1  clock; same clock as the step counter.
reset  in  1  synchronous, active-high reset.
t  in  TW  current step-counter value.
cfg_valid  in  1  config request.
cfg_ready  out  1  config accepted this cycle when cfg_valid&cfg_ready.
cfg_match  in  TW  step value that generates an event.
cfg_periodic  in  1  1 = event every epoch; 0 = single event, then DONE.
stop  in  1  abort; return to IDLE.
evt_valid  out  1  FIFO head valid.
evt_ready  in  1  downstream accepts head.
evt_data  out  EPOCH_W+TW  {epoch, step} of the head event.
wrap_pulse  out  1  one-cycle pulse on a 31->0 transition.
resync  out  1  sticky: t discontinuity seen since last config.
ovf  out  1  sticky: event dropped because the FIFO was full.
busy  out  1  state != IDLE.

Behaviour:
- Reset (synchronous, active-high) values:
  - state=IDLE; t_q=0; epoch=0; FIFO empty.
  - evt_valid=0, wrap_pulse=0, resync=0, ovf=0, busy=0, cfg_ready=1, evt_data=0.
  - Reset asserted mid-operation discards queued events.
- t_q registers t every cycle.
  - wrap_pulse (registered, 1-cycle latency) = (t_q==2**TW-1) && (t==0).
  - Discontinuity = t != t_q+1 mod 2**TW. Evaluated only in ARM/RUN, not on the first cycle after reset or config. It sets resync (sticky) and forces state to ARM.
- States:
  - IDLE: cfg_ready=1. On cfg_valid: latch cfg_match and cfg_periodic; clear resync, ovf and epoch; go to ARM.
  - ARM: wait for a wrap condition (t_q==max, t==0), then go to RUN with epoch=0. Alignment ensures the first event is in epoch 0.
  - RUN:
    - When t==match_q, push {epoch, t} into the FIFO. In one-shot mode, go to DONE on the same edge.
    - On each wrap, epoch+=1, wrapping mod 2**EPOCH_W silently.
  - DONE: hold until the FIFO drains (evt_valid=0), then go to IDLE.
  - stop in ARM/RUN/DONE -> IDLE next cycle. The FIFO is retained and drains normally.
  - cfg_ready=0 outside IDLE. cfg_valid outside IDLE is ignored.
- Match and wrap on the same cycle (match_q==0): the push uses the pre-increment epoch, then epoch increments.
- FIFO:
  - First-word fall-through. evt_data is valid the cycle after the push.
  - Pop when evt_valid&evt_ready.
  - Push and pop on the same cycle while full: both succeed, no ovf.
  - Push when full without a pop: event dropped, ovf=1 (sticky until next config).
  - evt_data holds its value while evt_valid&~evt_ready.
- Match at step m: the push is at the edge where t==m, so evt_valid rises 1 cycle later.
- busy = (state != IDLE).

Decomposition:
- Shared package step_pkg:
  - TW, EPOCH_W constants.
  - State enum {IDLE, ARM, RUN, DONE}.
  - Event struct {epoch, step}.
- One sub-module: evt_fifo (parameterised DEPTH/width sync FIFO with full/empty, FWFT). Reusable by other stages.

Test Plan:
- Reset, then cfg match=5, periodic=0, with t counting from 0 -> ARM until 31->0. Then exactly one event, evt_data={3'd0,5'd5}, one cycle after t==5. State goes DONE -> IDLE after pop; cfg_ready returns to 1.
- Periodic, match=0, evt_ready=1, run 3 full periods -> wrap_pulse 3 times; events {0,0},{1,0},{2,0}. Epoch wraps 7->0 after 8 epochs with no flag.
- Periodic, match=3, evt_ready=0 for 3 epochs -> 2 events queued with epochs 0,1; third dropped, ovf=1. Release evt_ready -> events drain in order.
- In RUN at t=10, force t to 20 -> resync=1, state ARM, no event until the next 31->0. After the next config, resync=0.
- FIFO full with evt_ready=1 and a push on the same cycle -> no ovf, occupancy unchanged, order preserved.
- reset asserted mid-RUN with 1 queued event -> next cycle evt_valid=0, busy=0, cfg_ready=1, all sticky flags 0.

Source files
------------

// File: rtl/step_pkg.sv
// Shared definitions for the step-counter consumer stage.
//   TW      : width of the free-running step counter value
//   EPOCH_W : width of the completed-wrap (epoch) counter
//   state_e : sequencing states of step_event_gen
//   evt_t   : layout of one queued event, {epoch, step}
package step_pkg;

  localparam int unsigned TW      = 5;
  localparam int unsigned EPOCH_W = 3;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StRun,
    StDone
  } state_e;

  typedef struct packed {
    logic [EPOCH_W-1:0] epoch;
    logic [TW-1:0]      step;
  } evt_t;

endpackage

// File: rtl/evt_fifo.sv
// Small synchronous first-word-fall-through FIFO.
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   push/wdata : write request; accepted when not full, or when full with a pop
//   pop        : remove head; ignored when empty
//   rdata      : head entry, reads as zero while empty
//   full/empty : occupancy flags
module evt_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] Cap = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == Cap);
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/step_event_gen.sv
// Consumer of the free-running step counter: tracks wraps and discontinuities,
// counts epochs and queues {epoch, step} events when t hits a programmed step.
//   clk, reset            : clock, synchronous active-high reset
//   t                     : current step-counter value
//   cfg_valid/cfg_ready   : config handshake, accepted only while idle
//   cfg_match/cfg_periodic: event step, periodic (1) or one-shot (0)
//   stop                  : abort back to idle; queued events still drain
//   evt_valid/ready/data  : event FIFO head handshake
//   wrap_pulse            : registered pulse for a max->0 transition of t
//   resync, ovf           : sticky discontinuity / dropped-event flags
//   busy                  : sequencer not idle
module step_event_gen #(
  parameter int unsigned TW      = step_pkg::TW,
  parameter int unsigned EPOCH_W = step_pkg::EPOCH_W,
  parameter int unsigned DEPTH   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [TW-1:0]         t,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [TW-1:0]         cfg_match,
  input  logic                  cfg_periodic,
  input  logic                  stop,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [EPOCH_W+TW-1:0] evt_data,
  output logic                  wrap_pulse,
  output logic                  resync,
  output logic                  ovf,
  output logic                  busy
);

  import step_pkg::*;

  localparam logic [TW-1:0] TMax = '1;

  state_e               state_q;
  logic [TW-1:0]        t_q, match_q, t_inc;
  logic [EPOCH_W-1:0]   epoch_q;
  logic                 periodic_q, skip_q, wrap_pulse_q, resync_q, ovf_q;
  logic                 wrap, tracking, disc, match_hit, pop, fifo_full, fifo_empty;
  logic [EPOCH_W+TW-1:0] push_data;

  assign t_inc     = t_q + TW'(1);
  assign wrap      = (t_q == TMax) && (t == '0);
  assign tracking  = (state_q == StArm) || (state_q == StRun);
  // The first cycle after config compares against a t_q captured before
  // tracking began, so it is not a real discontinuity.
  assign disc      = tracking && !skip_q && (t != t_inc);
  assign match_hit = (state_q == StRun) && !stop && !disc && (t == match_q);
  // Epoch is the pre-increment value when match and wrap coincide.
  assign push_data = {epoch_q, t};
  assign pop       = evt_valid && evt_ready;

  evt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EPOCH_W + TW)
  ) u_evt_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (match_hit),
    .wdata (push_data),
    .pop   (pop),
    .rdata (evt_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign evt_valid  = !fifo_empty;
  assign cfg_ready  = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign wrap_pulse = wrap_pulse_q;
  assign resync     = resync_q;
  assign ovf        = ovf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      t_q          <= '0;
      match_q      <= '0;
      periodic_q   <= 1'b0;
      epoch_q      <= '0;
      skip_q       <= 1'b1;
      wrap_pulse_q <= 1'b0;
      resync_q     <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      t_q          <= t;
      wrap_pulse_q <= wrap;
      skip_q       <= 1'b0;

      if (match_hit && fifo_full && !pop) ovf_q <= 1'b1;

      if (state_q == StIdle) begin
        if (cfg_valid) begin
          match_q    <= cfg_match;
          periodic_q <= cfg_periodic;
          resync_q   <= 1'b0;
          ovf_q      <= 1'b0;
          epoch_q    <= '0;
          skip_q     <= 1'b1;
          state_q    <= StArm;
        end
      end else if (stop) begin
        state_q <= StIdle;
      end else if (disc) begin
        resync_q <= 1'b1;
        state_q  <= StArm;
      end else begin
        case (state_q)
          StArm: begin
            // Start on a wrap so the first event lands in epoch 0.
            if (wrap) begin
              epoch_q <= '0;
              state_q <= StRun;
            end
          end
          StRun: begin
            if (wrap) epoch_q <= epoch_q + EPOCH_W'(1);
            if (match_hit && !periodic_q) state_q <= StDone;
          end
          StDone: begin
            if (!evt_valid) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_step_event_gen.sv
module tb_step_event_gen;

  localparam int DEPTH   = 2;
  localparam int PH_IDLE = 0;
  localparam int PH_ARM  = 1;
  localparam int PH_RUN  = 2;
  localparam int PH_DONE = 3;

  logic       clk = 1'b0;
  logic       reset, cfg_valid, cfg_ready, cfg_periodic, stop;
  logic       evt_valid, evt_ready, wrap_pulse, resync, ovf, busy;
  logic [4:0] t, cfg_match;
  logic [7:0] evt_data;

  always #5 clk = ~clk;

  step_event_gen #(
    .TW      (5),
    .EPOCH_W (3),
    .DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .t            (t),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_match    (cfg_match),
    .cfg_periodic (cfg_periodic),
    .stop         (stop),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_data     (evt_data),
    .wrap_pulse   (wrap_pulse),
    .resync       (resync),
    .ovf          (ovf),
    .busy         (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard: events the reference model says the DUT has accepted.
  logic [7:0] exp_q[$];

  // Stimulus for the next edge.
  bit in_reset, in_cfg_valid, in_periodic, in_stop, in_ready;
  int in_match;
  int tcur;

  // Reference model state.
  int m_phase, m_count, m_epoch, m_prev, m_match;
  bit m_periodic, m_resync, m_ovf, m_wrap, m_first;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model of one clock edge, applied to the inputs being driven.
  task automatic model_step();
    bit pop, wrap, disc, push, first_next;
    int ep_pre;
    pop = (m_count > 0) && in_ready;
    if (in_reset) begin
      m_phase = PH_IDLE; m_count = 0; m_epoch = 0; m_prev = 0;
      m_resync = 0; m_ovf = 0; m_wrap = 0; m_first = 0;
      exp_q.delete();
    end else begin
      wrap = (m_prev == 31) && (tcur == 0);
      disc = (m_phase == PH_ARM || m_phase == PH_RUN) && !m_first &&
             (tcur != (m_prev + 1) % 32);
      push = 0;
      first_next = 0;
      ep_pre = m_epoch;
      if (m_phase == PH_IDLE) begin
        if (in_cfg_valid) begin
          m_match = in_match; m_periodic = in_periodic;
          m_resync = 0; m_ovf = 0; m_epoch = 0;
          first_next = 1; m_phase = PH_ARM;
        end
      end else if (in_stop) begin
        m_phase = PH_IDLE;
      end else if (disc) begin
        m_resync = 1; m_phase = PH_ARM;
      end else if (m_phase == PH_ARM) begin
        if (wrap) begin m_phase = PH_RUN; m_epoch = 0; end
      end else if (m_phase == PH_RUN) begin
        push = (tcur == m_match);
        if (wrap) m_epoch = (m_epoch + 1) % 8;
        if (push && !m_periodic) m_phase = PH_DONE;
      end else begin
        if (m_count == 0) m_phase = PH_IDLE;
      end
      if (push) begin
        if (m_count < DEPTH || pop) begin
          exp_q.push_back({3'(ep_pre), 5'(tcur)});
          m_count++;
        end else begin
          m_ovf = 1;
        end
      end
      if (pop) m_count--;
      m_wrap  = wrap;
      m_prev  = tcur;
      m_first = first_next;
    end
  endtask

  task automatic compare_outputs();
    check("evt_valid", int'(evt_valid), int'(m_count > 0));
    check("busy", int'(busy), int'(m_phase != PH_IDLE));
    check("cfg_ready", int'(cfg_ready), int'(m_phase == PH_IDLE));
    check("resync", int'(resync), int'(m_resync));
    check("ovf", int'(ovf), int'(m_ovf));
    check("wrap_pulse", int'(wrap_pulse), int'(m_wrap));
    if (m_count == 0) check("evt_data_empty", int'(evt_data), 0);
  endtask

  // Drive one cycle, advance the model, then check after the edge settles.
  task automatic tick();
    model_step();
    reset        = in_reset;
    cfg_valid    = in_cfg_valid;
    cfg_match    = 5'(in_match);
    cfg_periodic = in_periodic;
    stop         = in_stop;
    evt_ready    = in_ready;
    t            = 5'(tcur);
    tcur         = (tcur + 1) % 32;
    @(negedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cfg(input int match, input bit periodic);
    in_cfg_valid = 1; in_match = match; in_periodic = periodic;
    tick();
    in_cfg_valid = 0;
  endtask

  task automatic go_idle();
    in_stop = 1; tick(); in_stop = 0;
    in_ready = 1; run(4);
  endtask

  // Monitor: pops the scoreboard whenever a handshake is presented.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset && evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_event: got data %0h expected no event", evt_data);
        end else begin
          check("evt_data", int'(evt_data), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    in_reset = 1; in_cfg_valid = 0; in_periodic = 0; in_stop = 0; in_ready = 0;
    in_match = 0; tcur = 0;
    run(2);
    in_reset = 0;
    tcur = 0;

    // One-shot at step 5, consumer stalled for a while before draining.
    cfg(5, 0);
    run(45);
    in_ready = 1;
    run(6);

    // Periodic at step 0 across more than eight epochs.
    go_idle();
    cfg(0, 1);
    run(32 * 10 + 8);

    // Periodic at step 3 with consumer stalled: two queue, later ones drop.
    go_idle();
    in_ready = 0;
    cfg(3, 1);
    run(32 * 4);
    in_ready = 1;
    run(8);

    // Discontinuity while running.
    go_idle();
    cfg(12, 1);
    run(40);
    while (tcur != 10) tick();
    tcur = 20;
    run(30);
    go_idle();
    cfg(12, 1);
    run(3);

    // Full FIFO with a push and pop on the same edge.
    go_idle();
    while (tcur != 30) tick();
    in_ready = 0;
    cfg(3, 1);
    for (int i = 0; i < 100 && m_count < 2; i++) tick();
    while (tcur != 3) tick();
    in_ready = 1;
    tick();
    in_ready = 0;
    run(3);
    in_ready = 1;
    run(4);

    // Reset while running with an event queued.
    go_idle();
    in_ready = 0;
    cfg(3, 1);
    run(40);
    in_reset = 1; tick(); in_reset = 0;
    run(3);

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) begin
      in_ready     = ($urandom_range(0, 3) != 0);
      in_cfg_valid = ($urandom_range(0, 15) == 0);
      in_match     = $urandom_range(0, 31);
      in_periodic  = $urandom_range(0, 1);
      in_stop      = ($urandom_range(0, 199) == 0);
      in_reset     = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 149) == 0) tcur = $urandom_range(0, 31);
      tick();
    end
    in_cfg_valid = 0; in_reset = 0;

    go_idle();
    run(4);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
